// File: rtl/noc_local_port.sv
// noc_local_port: router local port facing the PE.
// Injection: PE packets enter a small FIFO. Remote heads go to the router.
// Local heads loop back to the PE through the ejection arbiter.
// Ejection: router and loopback packets share a round-robin grant.
// Delivery to the PE is a registered, valid-only strobe.
module noc_local_port #(
    parameter int unsigned DATA_W     = 264,
    parameter int unsigned X_W        = 4,
    parameter int unsigned Y_W        = 4,
    parameter int unsigned MY_X       = 0,
    parameter int unsigned MY_Y       = 0,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [DATA_W-1:0] i_pe_data,
    input  logic              i_pe_valid,
    output logic              o_pe_ready,
    output logic [DATA_W-1:0] o_pe_data,
    output logic              o_pe_valid,
    output logic [DATA_W-1:0] o_rtr_data,
    output logic              o_rtr_valid,
    input  logic              i_rtr_ready,
    input  logic [DATA_W-1:0] i_rtr_data,
    input  logic              i_rtr_valid,
    output logic              o_rtr_ready,
    output logic [31:0]       o_inj_count,
    output logic [31:0]       o_ej_count
);

    localparam int unsigned     AW      = $clog2(FIFO_DEPTH);
    localparam logic [X_W-1:0]  MY_X_L  = X_W'(MY_X);
    localparam logic [Y_W-1:0]  MY_Y_L  = Y_W'(MY_Y);
    localparam logic [AW:0]     DEPTH_L = (AW+1)'(FIFO_DEPTH);

    // Records which requester won the most recent contested cycle.
    typedef enum logic {
        LAST_RTR  = 1'b0,
        LAST_LOOP = 1'b1
    } last_win_e;

    logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
    logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
    logic [AW:0]       cnt_q, cnt_d;
    last_win_e         last_q;
    logic              pe_valid_q;
    logic [DATA_W-1:0] pe_data_q;
    logic [31:0]       inj_cnt_q, ej_cnt_q;

    logic [DATA_W-1:0] head;
    logic              full, empty, head_local;
    logic              loop_req, loop_pri;
    logic              push, pop, loop_gnt, rtr_gnt, contest;

    // FIFO status, head routing and the ejection arbiter decision.
    // Outputs are forced low while rst is high so they drop immediately.
    always_comb begin
        full        = (cnt_q == DEPTH_L);
        empty       = (cnt_q == '0);
        head        = mem_q[rd_ptr_q];
        head_local  = (head[DATA_W-1 -: X_W] == MY_X_L) &&
                      (head[DATA_W-X_W-1 -: Y_W] == MY_Y_L);
        loop_req    = !rst && !empty && head_local;
        loop_pri    = (last_q == LAST_RTR);
        o_pe_ready  = !rst && !full;
        o_rtr_valid = !rst && !empty && !head_local;
        o_rtr_data  = rst ? '0 : head;
        o_rtr_ready = !rst && !(loop_req && loop_pri);
        push        = i_pe_valid && o_pe_ready;
        loop_gnt    = loop_req && (loop_pri || !i_rtr_valid);
        rtr_gnt     = i_rtr_valid && o_rtr_ready;
        pop         = (o_rtr_valid && i_rtr_ready) || loop_gnt;
        contest     = loop_req && i_rtr_valid;
        cnt_d       = cnt_q;
        if (push && !pop) begin
            cnt_d = cnt_q + (AW+1)'(1);
        end else if (!push && pop) begin
            cnt_d = cnt_q - (AW+1)'(1);
        end
    end

    // FIFO storage; contents need no reset because occupancy gates their use.
    always_ff @(posedge clk) begin
        if (push) begin
            mem_q[wr_ptr_q] <= i_pe_data;
        end
    end

    // Pointers, arbiter history, ejection register and counters.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            cnt_q      <= '0;
            last_q     <= LAST_RTR;
            pe_valid_q <= 1'b0;
            pe_data_q  <= '0;
            inj_cnt_q  <= '0;
            ej_cnt_q   <= '0;
        end else begin
            if (push) begin
                wr_ptr_q  <= wr_ptr_q + AW'(1);
                inj_cnt_q <= inj_cnt_q + 32'd1;
            end
            if (pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            cnt_q <= cnt_d;
            if (contest) begin
                last_q <= loop_pri ? LAST_LOOP : LAST_RTR;
            end
            pe_valid_q <= loop_gnt || rtr_gnt;
            if (loop_gnt) begin
                pe_data_q <= head;
            end else if (rtr_gnt) begin
                pe_data_q <= i_rtr_data;
            end
            if (loop_gnt || rtr_gnt) begin
                ej_cnt_q <= ej_cnt_q + 32'd1;
            end
        end
    end

    assign o_pe_valid  = pe_valid_q;
    assign o_pe_data   = pe_data_q;
    assign o_inj_count = inj_cnt_q;
    assign o_ej_count  = ej_cnt_q;

endmodule

// File: tb/tb_noc_local_port.sv
// Testbench for noc_local_port.
// Each cycle, outputs are compared against a queue-based reference model of the port.
// Stimulus is a sequence of directed scenarios followed by a randomized phase.
module tb_noc_local_port;

    localparam int DW    = 264;
    localparam int XW    = 4;
    localparam int YW    = 4;
    localparam int DEPTH = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [DW-1:0] i_pe_data = '0;
    logic          i_pe_valid = 1'b0;
    logic          o_pe_ready;
    logic [DW-1:0] o_pe_data;
    logic          o_pe_valid;
    logic [DW-1:0] o_rtr_data;
    logic          o_rtr_valid;
    logic          i_rtr_ready = 1'b0;
    logic [DW-1:0] i_rtr_data = '0;
    logic          i_rtr_valid = 1'b0;
    logic          o_rtr_ready;
    logic [31:0]   o_inj_count;
    logic [31:0]   o_ej_count;

    always #5 clk = ~clk;

    noc_local_port #(
        .DATA_W(DW), .X_W(XW), .Y_W(YW), .MY_X(0), .MY_Y(0), .FIFO_DEPTH(DEPTH)
    ) dut (
        .clk(clk), .rst(rst),
        .i_pe_data(i_pe_data), .i_pe_valid(i_pe_valid), .o_pe_ready(o_pe_ready),
        .o_pe_data(o_pe_data), .o_pe_valid(o_pe_valid),
        .o_rtr_data(o_rtr_data), .o_rtr_valid(o_rtr_valid), .i_rtr_ready(i_rtr_ready),
        .i_rtr_data(i_rtr_data), .i_rtr_valid(i_rtr_valid), .o_rtr_ready(o_rtr_ready),
        .o_inj_count(o_inj_count), .o_ej_count(o_ej_count)
    );

    int nvec = 0;
    int nbad = 0;

    // Reference model state: injection queue, round-robin priority, delivered packet, counts.
    logic [DW-1:0] mq[$];
    bit            m_lpri  = 1'b1;   // 1: loopback wins the next contest
    bit            m_known = 1'b0;   // registered outputs are defined only after the first reset
    bit            m_pv    = 1'b0;
    logic [DW-1:0] m_pd    = '0;
    logic [31:0]   m_inj   = '0;
    logic [31:0]   m_ej    = '0;

    task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
        nvec++;
        assert (obs === exp) else begin
            nbad++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    function automatic logic [255:0] rnd256();
        logic [255:0] v;
        for (int i = 0; i < 8; i++) v[i*32 +: 32] = $urandom;
        return v;
    endfunction

    function automatic logic [DW-1:0] pkt(input logic [3:0] x, input logic [3:0] y,
                                          input logic [255:0] pl);
        return {x, y, pl};
    endfunction

    function automatic logic [DW-1:0] rnd_pkt();
        logic [3:0] xs [4];
        logic [3:0] ys [4];
        int unsigned s;
        xs = '{4'd0, 4'd1, 4'd0, 4'd3};
        ys = '{4'd0, 4'd0, 4'd1, 4'd2};
        s  = $urandom_range(3);
        return pkt(xs[s], ys[s], rnd256());
    endfunction

    // One clock cycle.
    // Drive the inputs at the falling edge, then check the outputs mid low-phase.
    // Finally advance the model to its state after the next rising edge.
    task automatic step(input bit r, input bit pv, input logic [DW-1:0] pd,
                        input bit rr, input bit rv, input logic [DW-1:0] rd,
                        output bit acc, output bit rg);
        logic [DW-1:0] head;
        bit loc, e_ready, e_rv, lreq, e_rrdy, lg, pop;
        @(negedge clk);
        rst = r; i_pe_valid = pv; i_pe_data = pd;
        i_rtr_ready = rr; i_rtr_valid = rv; i_rtr_data = rd;
        #2;
        head    = (mq.size() > 0) ? mq[0] : '0;
        loc     = (mq.size() > 0) && (head[DW-1 -: XW] == 4'd0) && (head[DW-XW-1 -: YW] == 4'd0);
        e_ready = !r && (mq.size() < DEPTH);
        e_rv    = !r && (mq.size() > 0) && !loc;
        lreq    = !r && loc;
        e_rrdy  = !r && !(lreq && m_lpri);
        chk("pe_ready",  DW'(o_pe_ready),  DW'(e_ready));
        chk("rtr_valid", DW'(o_rtr_valid), DW'(e_rv));
        chk("rtr_ready", DW'(o_rtr_ready), DW'(e_rrdy));
        if (e_rv) chk("rtr_data", o_rtr_data, head);
        if (r)    chk("rtr_data_rst", o_rtr_data, '0);
        if (m_known) begin
            chk("pe_valid",  DW'(o_pe_valid),  DW'(m_pv));
            chk("pe_data",   o_pe_data,         m_pd);
            chk("inj_count", DW'(o_inj_count), DW'(m_inj));
            chk("ej_count",  DW'(o_ej_count),  DW'(m_ej));
        end
        acc = 1'b0;
        rg  = 1'b0;
        if (r) begin
            mq.delete();
            m_lpri = 1'b1; m_known = 1'b1; m_pv = 1'b0; m_pd = '0; m_inj = '0; m_ej = '0;
        end else begin
            acc = pv && e_ready;
            lg  = lreq && (m_lpri || !rv);
            rg  = rv && e_rrdy;
            pop = (e_rv && rr) || lg;
            if (lreq && rv) m_lpri = !m_lpri;
            m_pv = lg || rg;
            if (lg)      m_pd = head;
            else if (rg) m_pd = rd;
            if (m_pv) m_ej++;
            if (pop) void'(mq.pop_front());
            if (acc) begin
                mq.push_back(pd);
                m_inj++;
            end
        end
    endtask

    initial begin
        bit a, g;
        int k;
        logic [DW-1:0] burst [6];
        logic [DW-1:0] rpk [3];
        logic [DW-1:0] lp;

        // Reset release: three cycles in reset, then idle.
        repeat (3) step(1, 0, '0, 0, 0, '0, a, g);
        repeat (2) step(0, 0, '0, 0, 0, '0, a, g);

        // Remote burst with the router stalled, then drained.
        for (int i = 0; i < 6; i++) burst[i] = pkt(4'd1, 4'd0, rnd256());
        k = 0;
        repeat (7) begin
            step(0, k < 6, burst[(k < 6) ? k : 0], 0, 0, '0, a, g);
            if (a) k++;
        end
        repeat (12) begin
            step(0, k < 6, burst[(k < 6) ? k : 0], 1, 0, '0, a, g);
            if (a) k++;
        end

        // Single loopback packet.
        lp = pkt(4'd0, 4'd0, 256'hA5);
        step(0, 1, lp, 1, 0, '0, a, g);
        repeat (4) step(0, 0, '0, 1, 0, '0, a, g);

        // Contention: loopback head pending while the router offers three packets.
        for (int i = 0; i < 3; i++) rpk[i] = rnd_pkt();
        step(0, 1, pkt(4'd0, 4'd0, rnd256()), 1, 0, '0, a, g);
        k = 0;
        repeat (8) begin
            step(0, 0, '0, 1, k < 3, rpk[(k < 3) ? k : 0], a, g);
            if (g) k++;
        end

        // Head-of-line: a local packet then a remote one, with continuous ejection traffic.
        step(0, 1, pkt(4'd0, 4'd0, rnd256()), 1, 1, rnd_pkt(), a, g);
        step(0, 1, pkt(4'd2, 4'd1, rnd256()), 1, 1, rnd_pkt(), a, g);
        repeat (8) step(0, 0, '0, 1, 1, rnd_pkt(), a, g);

        // Randomized traffic.
        repeat (300) step(0, $urandom_range(1), rnd_pkt(), $urandom_range(1),
                          $urandom_range(1), rnd_pkt(), a, g);

        // Reset in the middle of operation, with three packets held in the FIFO.
        repeat (6) step(0, 0, '0, 1, 0, '0, a, g);
        repeat (3) step(0, 1, pkt(4'd1, 4'd0, rnd256()), 0, 0, '0, a, g);
        repeat (2) step(1, 0, '0, 0, 0, '0, a, g);
        repeat (3) step(0, 0, '0, 1, 0, '0, a, g);

        // Injection counter wrap.
        step(0, 0, '0, 1, 0, '0, a, g);
        force dut.inj_cnt_q = 32'hFFFF_FFFF;
        #1;
        release dut.inj_cnt_q;
        m_inj = 32'hFFFF_FFFF;
        step(0, 1, pkt(4'd1, 4'd0, rnd256()), 1, 0, '0, a, g);
        repeat (3) step(0, 0, '0, 1, 0, '0, a, g);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nbad);
        $finish;
    end

endmodule
